// File: rtl/feed_forward_layer_if.sv
// Bus bundle for feed_forward_layer: input-vector stream, weight/bias
// write port and result stream. The layer itself uses the slave view.
interface feed_forward_layer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     i_valid;
  logic [DATA_WIDTH-1:0]    i_data;
  logic                     o_in_ready;

  logic                     i_w_we;
  logic [ADDRESS_WIDTH-1:0] i_w_addr;
  logic [DATA_WIDTH-1:0]    i_w_data;
  logic                     i_b_we;
  logic [ADDRESS_WIDTH-1:0] i_b_addr;
  logic [DATA_WIDTH-1:0]    i_b_data;
  logic                     o_w_ready;

  logic                     o_valid;
  logic [DATA_WIDTH-1:0]    o_data;
  logic [ADDRESS_WIDTH-1:0] o_node;
  logic                     o_last;
  logic                     i_ready;

  modport slave (
    input  i_valid, i_data, i_w_we, i_w_addr, i_w_data,
           i_b_we, i_b_addr, i_b_data, i_ready,
    output o_in_ready, o_w_ready, o_valid, o_data, o_node, o_last
  );

  modport master (
    output i_valid, i_data, i_w_we, i_w_addr, i_w_data,
           i_b_we, i_b_addr, i_b_data, i_ready,
    input  o_in_ready, o_w_ready, o_valid, o_data, o_node, o_last
  );
endinterface

// File: rtl/feed_forward_layer.sv
// Fully connected layer, one neuron at a time with a single MAC.
// Collects an input vector, then for each output node presets the
// accumulator with the scaled bias, runs one MAC per input element,
// and presents a rounded-down, saturated (optionally ReLU'd) result.
//
// state   | meaning
// LOAD    | collecting input elements; weight/bias writes open while empty
// COMPUTE | step 0 presets bias, steps 1..N accumulate x[k]*w[node][k]
// OUTPUT  | result held on o_data until the consumer takes it
module feed_forward_layer #(
  parameter int DATA_WIDTH            = 32,
  parameter int FRAC_BITS             = 16,
  parameter int NUMBER_OF_INPUT_NODE  = 2,
  parameter int NUMBER_OF_OUTPUT_NODE = 4,
  parameter int ADDRESS_WIDTH         = 5,
  parameter int ACTIVATION            = 1
) (
  input logic clk,
  input logic rst,
  feed_forward_layer_if.slave bus
);

  localparam int DW      = DATA_WIDTH;
  localparam int NI      = NUMBER_OF_INPUT_NODE;
  localparam int NO      = NUMBER_OF_OUTPUT_NODE;
  localparam int ACC_W   = 2 * DW + $clog2(NI) + 1;
  localparam int W_DEPTH = NI * NO;
  localparam int W_IDX_W = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int B_IDX_W = (NO > 1) ? $clog2(NO) : 1;
  localparam int X_IDX_W = (NI > 1) ? $clog2(NI) : 1;
  localparam int STEP_W  = $clog2(NI + 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t state, state_next;

  logic [X_IDX_W-1:0]       elem_cnt;
  logic [STEP_W-1:0]        step;
  logic [ADDRESS_WIDTH-1:0] node;
  logic signed [ACC_W-1:0]  acc;

  // Weights, biases and the captured vector are plain storage without reset.
  logic [DW-1:0] x_mem [NI];
  logic [DW-1:0] w_mem [W_DEPTH];
  logic [DW-1:0] b_mem [NO];

  logic in_hs, last_elem, last_step, last_node, wr_open;
  logic [X_IDX_W-1:0]        mac_idx;
  logic [W_IDX_W-1:0]        w_rd_idx;
  logic [B_IDX_W-1:0]        b_rd_idx;
  logic [DW-1:0]             x_word, w_word, b_word;
  logic signed [2*DW-1:0]    x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, acc_next, bias_ext, shifted;
  logic [ACC_W-DW:0]         upper;
  logic [DW-1:0]             sat_val, result;

  assign in_hs     = (state == LOAD) && bus.i_valid;
  assign last_elem = (elem_cnt == X_IDX_W'(NI - 1));
  assign last_step = (step == STEP_W'(NI));
  assign last_node = (node == ADDRESS_WIDTH'(NO - 1));
  assign wr_open   = (state == LOAD) && (elem_cnt == '0);

  // MAC datapath and result shaping (floor shift, saturate, activation).
  always_comb begin
    mac_idx  = X_IDX_W'(step - 1'b1);
    w_rd_idx = W_IDX_W'(32'(node) * NI + 32'(mac_idx));
    b_rd_idx = B_IDX_W'(node);
    x_word   = x_mem[mac_idx];
    w_word   = w_mem[w_rd_idx];
    b_word   = b_mem[b_rd_idx];
    x_ext    = $signed({{DW{x_word[DW-1]}}, x_word});
    w_ext    = $signed({{DW{w_word[DW-1]}}, w_word});
    prod     = x_ext * w_ext;
    prod_ext = $signed({{(ACC_W-2*DW){prod[2*DW-1]}}, prod});
    acc_next = acc + prod_ext;
    bias_ext = $signed({{(ACC_W-DW){b_word[DW-1]}}, b_word}) <<< FRAC_BITS;
    shifted  = acc_next >>> FRAC_BITS;
    upper    = shifted[ACC_W-1:DW-1];
    if ((&upper) || !(|upper)) begin
      sat_val = shifted[DW-1:0];
    end else if (shifted[ACC_W-1]) begin
      sat_val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(DW-1){1'b1}}};
    end
    result = sat_val;
    if (ACTIVATION == 1 && sat_val[DW-1]) begin
      result = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next     = state;
    bus.o_in_ready = 1'b0;
    bus.o_valid    = 1'b0;
    bus.o_w_ready  = wr_open;
    case (state)
      LOAD: begin
        bus.o_in_ready = 1'b1;
        if (bus.i_valid && last_elem) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (last_step) state_next = OUTPUT;
      end
      OUTPUT: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) state_next = last_node ? LOAD : COMPUTE;
      end
      default: state_next = LOAD;
    endcase
  end

  // Counters, accumulator and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_cnt   <= '0;
      step       <= '0;
      node       <= '0;
      acc        <= '0;
      bus.o_data <= '0;
      bus.o_node <= '0;
      bus.o_last <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          step <= '0;
          if (in_hs) begin
            elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
            if (last_elem) node <= '0;
          end
        end
        COMPUTE: begin
          step <= last_step ? '0 : step + 1'b1;
          acc  <= (step == '0) ? bias_ext : acc_next;
          if (last_step) begin
            bus.o_data <= result;
            bus.o_node <= node;
            bus.o_last <= last_node;
          end
        end
        OUTPUT: begin
          if (bus.i_ready) begin
            if (last_node) begin
              node     <= '0;
              elem_cnt <= '0;
            end else begin
              node <= node + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Vector capture and gated weight/bias writes (out-of-range addresses dropped).
  always_ff @(posedge clk) begin
    if (in_hs) x_mem[elem_cnt] <= bus.i_data;
    if (wr_open && bus.i_w_we && (32'(bus.i_w_addr) < W_DEPTH))
      w_mem[W_IDX_W'(bus.i_w_addr)] <= bus.i_w_data;
    if (wr_open && bus.i_b_we && (32'(bus.i_b_addr) < NO))
      b_mem[B_IDX_W'(bus.i_b_addr)] <= bus.i_b_data;
  end

endmodule

// File: tb/tb_feed_forward_layer.sv
// Bench for feed_forward_layer: drives a ReLU and a linear instance with
// identical stimulus; expected results come from a plain-arithmetic model
// and are checked by a monitor as each result is taken.
module tb_feed_forward_layer;
  localparam int NI = 2;
  localparam int NO = 2;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  node;
    logic        last;
  } exp_t;

  logic        clk, rst;
  logic        i_valid, i_w_we, i_b_we, i_ready;
  logic [31:0] i_data, i_w_data, i_b_data;
  logic [4:0]  i_w_addr, i_b_addr;

  int total = 0;
  int bad   = 0;

  int w_m [NI*NO];
  int b_m [NO];
  int x_m [NI];

  exp_t exp_q [2][$];

  logic        m_prev_v [2];
  logic        m_prev_r [2];
  logic [31:0] m_prev_d [2];
  logic [4:0]  m_prev_n [2];
  logic        m_prev_l [2];
  bit          m_expect_next [2];
  int          m_gap [2];

  feed_forward_layer_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus_r ();
  feed_forward_layer_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus_l ();

  assign bus_r.i_valid = i_valid;  assign bus_l.i_valid = i_valid;
  assign bus_r.i_data = i_data;    assign bus_l.i_data = i_data;
  assign bus_r.i_w_we = i_w_we;    assign bus_l.i_w_we = i_w_we;
  assign bus_r.i_w_addr = i_w_addr; assign bus_l.i_w_addr = i_w_addr;
  assign bus_r.i_w_data = i_w_data; assign bus_l.i_w_data = i_w_data;
  assign bus_r.i_b_we = i_b_we;    assign bus_l.i_b_we = i_b_we;
  assign bus_r.i_b_addr = i_b_addr; assign bus_l.i_b_addr = i_b_addr;
  assign bus_r.i_b_data = i_b_data; assign bus_l.i_b_data = i_b_data;
  assign bus_r.i_ready = i_ready;  assign bus_l.i_ready = i_ready;

  feed_forward_layer #(
    .DATA_WIDTH(32), .FRAC_BITS(16), .NUMBER_OF_INPUT_NODE(NI),
    .NUMBER_OF_OUTPUT_NODE(NO), .ADDRESS_WIDTH(5), .ACTIVATION(1)
  ) dut_relu (.clk(clk), .rst(rst), .bus(bus_r.slave));

  feed_forward_layer #(
    .DATA_WIDTH(32), .FRAC_BITS(16), .NUMBER_OF_INPUT_NODE(NI),
    .NUMBER_OF_OUTPUT_NODE(NO), .ADDRESS_WIDTH(5), .ACTIVATION(0)
  ) dut_lin (.clk(clk), .rst(rst), .bus(bus_l.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  // Reference: real-valued neuron in Q16 using 64-bit integers.
  function automatic logic [31:0] model(input int node, input bit relu);
    longint acc, r;
    acc = longint'(b_m[node]) * 65536;
    for (int k = 0; k < NI; k++) acc += longint'(x_m[k]) * longint'(w_m[node*NI + k]);
    r = acc >>> 16;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    if (relu && r < 0) r = 0;
    return r[31:0];
  endfunction

  function automatic int rnd();
    return int'($urandom_range(32'hFFFFFF, 0)) - 32'sh800000;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int n = 0; n < NO; n++) begin
      e.node = 5'(n);
      e.last = (n == NO - 1);
      e.data = model(n, 1'b1); exp_q[0].push_back(e);
      e.data = model(n, 1'b0); exp_q[1].push_back(e);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [31:0] d, input logic [4:0] n,
                     input logic l, input logic inr);
    exp_t e;
    if (rst) begin
      exp_q[id].delete();
      m_prev_v[id] = 1'b0;
      m_expect_next[id] = 1'b0;
      m_gap[id] = 0;
      return;
    end
    m_gap[id]++;
    if (m_prev_v[id] && !m_prev_r[id]) begin
      chk($sformatf("d%0d_hold_valid", id), v, 1'b1);
      chk($sformatf("d%0d_hold_data", id), d, m_prev_d[id]);
      chk($sformatf("d%0d_hold_node", id), n, m_prev_n[id]);
      chk($sformatf("d%0d_hold_last", id), l, m_prev_l[id]);
    end
    if (v) begin
      chk($sformatf("d%0d_in_ready_busy", id), inr, 1'b0);
      if (m_expect_next[id]) begin
        chk($sformatf("d%0d_node_latency", id), m_gap[id] - 1, NI + 1);
        m_expect_next[id] = 1'b0;
      end
      if (i_ready) begin
        if (exp_q[id].size() == 0) begin
          total++; bad++;
          $display("FAIL d%0d_extra_result: got node=%0d data=%0h want none", id, n, d);
        end else begin
          e = exp_q[id].pop_front();
          chk($sformatf("d%0d_data_n%0d", id, e.node), d, e.data);
          chk($sformatf("d%0d_node", id), n, e.node);
          chk($sformatf("d%0d_last", id), l, e.last);
        end
        m_expect_next[id] = !l;
        m_gap[id] = 0;
      end
    end
    m_prev_v[id] = v; m_prev_r[id] = i_ready;
    m_prev_d[id] = d; m_prev_n[id] = n; m_prev_l[id] = l;
  endtask

  // Monitor samples both instances midway between rising edges.
  always @(negedge clk) begin
    mon(0, bus_r.o_valid, bus_r.o_data, bus_r.o_node, bus_r.o_last, bus_r.o_in_ready);
    mon(1, bus_l.o_valid, bus_l.o_data, bus_l.o_node, bus_l.o_last, bus_l.o_in_ready);
  end

  task automatic wait_idle();
    int n = 0;
    while (!(bus_r.o_w_ready && bus_l.o_w_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_idle", bus_r.o_w_ready && bus_l.o_w_ready, 1'b1);
  endtask

  task automatic do_write(input bit bias, input int addr, input int val);
    if (bias) begin i_b_we = 1'b1; i_b_addr = 5'(addr); i_b_data = val; end
    else      begin i_w_we = 1'b1; i_w_addr = 5'(addr); i_w_data = val; end
    @(posedge clk); #1;
    i_w_we = 1'b0; i_b_we = 1'b0;
    if (!bias && addr >= 0 && addr < NI*NO) w_m[addr] = val;
    if (bias && addr >= 0 && addr < NO) b_m[addr] = val;
  endtask

  task automatic send_vector(input int x0, input int x1,
                             input bit gate_wr, input int g_addr, input int g_val,
                             input bit first_wr, input int f_addr, input int f_val);
    int lat = 0;
    wait_idle();
    i_valid = 1'b1; i_data = x0;
    if (first_wr) begin
      i_w_we = 1'b1; i_w_addr = 5'(f_addr); i_w_data = f_val;
      if (f_addr < NI*NO) w_m[f_addr] = f_val;
    end
    @(posedge clk); #1;
    i_w_we = 1'b0;
    chk("in_ready_mid_vector", bus_r.o_in_ready, 1'b1);
    chk("w_ready_mid_vector", bus_r.o_w_ready, 1'b0);
    i_data = x1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    x_m[0] = x0; x_m[1] = x1;
    push_expected();
    if (gate_wr) begin i_w_we = 1'b1; i_w_addr = 5'(g_addr); i_w_data = g_val; end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      i_w_we = 1'b0;
      if (bus_r.o_valid) begin lat = c; break; end
    end
    chk("first_latency", lat, NI + 1);
    chk("lin_valid_aligned", bus_l.o_valid, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_w_we = 1'b0; i_w_addr = '0; i_w_data = '0;
    i_b_we = 1'b0; i_b_addr = '0; i_b_data = '0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus_r.o_valid, 1'b0);
    chk("rst_in_ready", bus_r.o_in_ready, 1'b1);
    chk("rst_w_ready", bus_r.o_w_ready, 1'b1);
    chk("rst_data", bus_r.o_data, 32'h0);
    chk("rst_node", bus_r.o_node, 5'h0);
    chk("rst_last", bus_r.o_last, 1'b0);
    rst = 1'b0;

    // basic + ReLU vs linear on node 1
    do_write(0, 0, 32'h00008000); do_write(0, 1, 32'h00004000); do_write(1, 0, 32'h00002000);
    do_write(0, 2, 32'hFFFF0000); do_write(0, 3, 32'h00008000); do_write(1, 1, 32'hFFFF8000);
    send_vector(32'h00010000, 32'h00020000, 0, 0, 0, 0, 0, 0);
    chk("basic_node0_data", bus_r.o_data, 32'h00012000);
    chk("basic_node0_last", bus_r.o_last, 1'b0);

    // saturation both directions
    wait_idle();
    do_write(0, 0, 32'h7FFF0000); do_write(0, 1, 32'h7FFF0000); do_write(1, 0, 0);
    do_write(0, 2, 32'h80010000); do_write(0, 3, 32'h80010000); do_write(1, 1, 0);
    send_vector(32'h00020000, 32'h00020000, 0, 0, 0, 0, 0, 0);
    chk("sat_pos", bus_r.o_data, 32'h7FFFFFFF);

    // backpressure for three cycles
    wait_idle();
    do_write(0, 0, 32'h00008000); do_write(0, 1, 32'h00004000); do_write(1, 0, 32'h00002000);
    do_write(0, 2, 32'hFFFF0000); do_write(0, 3, 32'h00008000); do_write(1, 1, 32'hFFFF8000);
    i_ready = 1'b0;
    send_vector(32'h00010000, 32'h00020000, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_valid", bus_r.o_valid, 1'b1);
      chk("bp_in_ready", bus_r.o_in_ready, 1'b0);
    end
    i_ready = 1'b1;

    // write during COMPUTE ignored, then applied from idle
    send_vector(32'h00030000, 32'hFFFF0000, 1, 0, 32'h00030000, 0, 0, 0);
    send_vector(32'h00030000, 32'hFFFF0000, 0, 0, 0, 0, 0, 0);
    wait_idle();
    do_write(0, 0, 32'h00030000);
    send_vector(32'h00030000, 32'hFFFF0000, 0, 0, 0, 0, 0, 0);

    // weight write in the same cycle as the first element
    send_vector(32'h00020000, 32'h00010000, 0, 0, 0, 1, 1, 32'h00018000);

    // out-of-range writes dropped
    wait_idle();
    do_write(0, 4, 32'h7FFFFFFF); do_write(0, 31, 32'h12345678);
    do_write(1, 2, 32'h7FFFFFFF); do_write(1, 5, 32'h00110000);
    send_vector(32'h00010000, 32'h00010000, 0, 0, 0, 0, 0, 0);

    // reset while node 1 is being computed
    send_vector(32'h00010000, 32'h00020000, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", bus_r.o_valid, 1'b0);
    chk("mid_rst_in_ready", bus_r.o_in_ready, 1'b1);
    chk("mid_rst_w_ready", bus_r.o_w_ready, 1'b1);
    chk("mid_rst_data", bus_r.o_data, 32'h0);
    chk("mid_rst_node", bus_r.o_node, 5'h0);
    rst = 1'b0;
    send_vector(32'h00020000, 32'hFFFF0000, 0, 0, 0, 0, 0, 0);

    // randomized vectors, weights and consumer readiness
    for (int v = 0; v < 25; v++) begin
      if (v % 3 == 0) begin
        wait_idle();
        for (int a = 0; a < NI*NO; a++) do_write(0, a, rnd());
        for (int b = 0; b < NO; b++) do_write(1, b, rnd());
      end
      i_ready = 1'($urandom_range(1, 0));
      send_vector(rnd(), rnd(), 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 60; c++) begin
        if (bus_r.o_w_ready) break;
        @(posedge clk); #1;
        i_ready = 1'($urandom_range(1, 0));
      end
      i_ready = 1'b1;
    end

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty_relu", exp_q[0].size(), 0);
    chk("queue_empty_lin", exp_q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
